// File: rtl/amiga_clk_pll.sv
// Digital stand-in for the Amiga clock-tree PLL: DDS phase accumulators clocked by a
// fast reference synthesize clk_sdram (c0), clk_114 (c1) and clk_28 (c2), plus a lock flag.
module amiga_clk_pll #(
   parameter int              ACC_W       = 32,
   parameter logic [ACC_W-1:0] INC_114    = 32'h4000_0000,
   parameter logic [ACC_W-1:0] INC_28     = 265512736,
   parameter logic [ACC_W-1:0] PHASE_C0   = 32'h9800_0000,
   parameter int              LOCK_CYCLES = 16
) (
   input  logic inclk0,
   input  logic areset,
   output logic c0,
   output logic c1,
   output logic c2,
   output logic locked
);

   localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

   logic [CNT_W-1:0] lock_cnt;
   logic [ACC_W-1:0] acc114;
   logic [ACC_W-1:0] acc28;
   logic [ACC_W-1:0] acc114_ph;

   // Lock counter saturates at LOCK_CYCLES; locked rises on the edge where it gets there
   always_ff @(posedge inclk0 or posedge areset) begin
      if (areset) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else begin
         if (lock_cnt != LOCK_MAX)
            lock_cnt <= lock_cnt + CNT_W'(1);
         if (lock_cnt == LOCK_LAST)
            locked <= 1'b1;
      end
   end

   // Accumulators start advancing only on the edge after the lock edge
   always_ff @(posedge inclk0 or posedge areset) begin
      if (areset) begin
         acc114 <= '0;
         acc28  <= '0;
      end else if (locked) begin
         acc114 <= acc114 + INC_114;
         acc28  <= acc28 + INC_28;
      end
   end

   assign acc114_ph = acc114 + PHASE_C0;

   assign c1 = locked & acc114[ACC_W-1];
   assign c0 = locked & acc114_ph[ACC_W-1];
   assign c2 = locked & acc28[ACC_W-1];

endmodule

// File: tb/tb_amiga_clk_pll.sv
// Directed bench for amiga_clk_pll: lock timing, c0/c1 cadence, c2 rate, async reset,
// and a second instance with short lock and slower 114 increment.
module tb_amiga_clk_pll;

   logic clk = 1'b0;
   logic areset = 1'b1;
   logic c0, c1, c2, locked;
   logic b_c0, b_c1, b_c2, b_locked;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   amiga_clk_pll dut (
      .inclk0(clk), .areset(areset), .c0(c0), .c1(c1), .c2(c2), .locked(locked)
   );

   amiga_clk_pll #(
      .LOCK_CYCLES(1), .INC_114(32'h2000_0000), .PHASE_C0(32'h0)
   ) dut_b (
      .inclk0(clk), .areset(areset), .c0(b_c0), .c1(b_c1), .c2(b_c2), .locked(b_locked)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge_sample;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Release reset at a falling edge and walk the 16-edge lock sequence
   task automatic lock_seq(input string tag);
      logic e;
      areset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         edge_sample();
         if (k < 16)
            check($sformatf("%s_prelock_%0d", tag, k), {28'd0, locked, c0, c1, c2}, 32'h0);
         else
            check($sformatf("%s_lock_edge", tag), {28'd0, locked, c0, c1, c2}, 32'hC);
         e = (((k - 1) % 8) >= 4);
         check($sformatf("%s_b_%0d", tag, k), {29'd0, b_locked, b_c0, b_c1}, {29'd0, 1'b1, e, e});
      end
   endtask

   logic [3:0] pat;
   int rises, bad_runs, runs, run_len;
   logic prev_c2, first_run;

   initial begin
      pat = 4'b1100;
      areset = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("reset_hold", {28'd0, locked, c0, c1, c2}, 32'h0);
      end
      check("reset_hold_b", {28'd0, b_locked, b_c0, b_c1, b_c2}, 32'h0);

      lock_seq("first");

      for (int j = 1; j <= 16; j++) begin
         edge_sample();
         check($sformatf("c1_pat_%0d", j), {31'd0, c1}, {31'd0, pat[j % 4]});
         check($sformatf("c0_pat_%0d", j), {31'd0, c0}, {31'd0, ~pat[j % 4]});
         check($sformatf("locked_hold_%0d", j), {31'd0, locked}, 32'h1);
      end

      // Assert reset between edges while locked; outputs must drop without a clock edge
      #2 areset = 1'b1;
      #1;
      check("async_rst", {28'd0, locked, c0, c1, c2}, 32'h0);
      check("async_rst_b", {31'd0, b_locked}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check("async_rst_hold", {28'd0, locked, c0, c1, c2}, 32'h0);
      end

      lock_seq("relock");

      rises = 0; bad_runs = 0; runs = 0; run_len = 1;
      prev_c2 = c2; first_run = 1'b1;
      for (int n = 1; n <= 16176; n++) begin
         edge_sample();
         if (n <= 8)
            check($sformatf("relock_c1_%0d", n), {31'd0, c1}, {31'd0, pat[n % 4]});
         if (c2 == prev_c2) begin
            run_len++;
         end else begin
            if (!first_run) begin
               runs++;
               if (run_len < 8 || run_len > 9) bad_runs++;
            end
            first_run = 1'b0;
            if (c2) rises++;
            run_len = 1;
         end
         prev_c2 = c2;
      end

      checks++;
      assert (rises >= 999 && rises <= 1001) else begin
         errors++;
         $error("FAIL c2_edges observed=%0d expected=1000+-1", rises);
      end
      check("c2_bad_runs", bad_runs, 32'd0);
      checks++;
      assert (runs >= 1990) else begin
         errors++;
         $error("FAIL c2_runs observed=%0d expected>=1990", runs);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
